// File: rtl/if_id_stage.sv
// IF stage PC register and IF/ID pipeline register with stall, redirect and flush.
// Optional STALL_COUNT_EN adds a saturating stall-cycle counter on Stall_Count.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        PCSrc,
    input  logic [31:0] Branch_Target,
    input  logic [31:0] Instr_in,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_PC4,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_Valid,
    output logic [4:0]  IF_ID_Rs,
    output logic [4:0]  IF_ID_Rt
`ifdef STALL_COUNT_EN
    ,
    output logic [31:0] Stall_Count
`endif
);

    localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    // Low target bits are dropped: fetch addresses are always word aligned.
    logic unused_bt;
    assign unused_bt = ^Branch_Target[1:0];

    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        pc_d     = pc_q;
        if (PCWrite) begin
            pc_d = PCSrc ? {Branch_Target[31:2], 2'b00} : pc_plus4;
        end
    end

    // A stall has priority over a flush so the branch is re-resolved once released.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (IF_ID_Write) begin
            if (PCSrc) begin
                instr_d = 32'h0000_0000;
                pc4_d   = 32'h0000_0000;
                valid_d = 1'b0;
            end else begin
                instr_d = Instr_in;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= ResetPcAligned;
            instr_q <= 32'h0000_0000;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign PC          = pc_q;
    assign IF_ID_PC4   = pc4_q;
    assign IF_ID_Instr = instr_q;
    assign IF_ID_Valid = valid_q;
    assign IF_ID_Rs    = instr_q[25:21];
    assign IF_ID_Rt    = instr_q[20:16];

`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PCWrite && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'h0000_0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Stall_Count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus randomized stall/redirect traffic
// checked every cycle against a behavioural pipeline model.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        PCWrite = 1'b1;
    logic        IF_ID_Write = 1'b1;
    logic        PCSrc = 1'b0;
    logic [31:0] Branch_Target = 32'h0;
    logic [31:0] Instr_in;
    logic [31:0] PC, IF_ID_PC4, IF_ID_Instr;
    logic        IF_ID_Valid;
    logic [4:0]  IF_ID_Rs, IF_ID_Rt;
`ifdef STALL_COUNT_EN
    logic [31:0] Stall_Count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    bit rand_mem = 1'b0;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pc4, m_sc;
    logic        m_valid;

    always #5 clk = ~clk;

    // Instruction memory: word equals address, or a scrambled word in random mode.
    assign Instr_in = rand_mem ? ((PC * 32'h9E37_79B1) ^ 32'h5A5A_1234) : PC;

    if_id_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk),
        .reset(reset),
        .PCWrite(PCWrite),
        .IF_ID_Write(IF_ID_Write),
        .PCSrc(PCSrc),
        .Branch_Target(Branch_Target),
        .Instr_in(Instr_in),
        .PC(PC),
        .IF_ID_PC4(IF_ID_PC4),
        .IF_ID_Instr(IF_ID_Instr),
        .IF_ID_Valid(IF_ID_Valid),
        .IF_ID_Rs(IF_ID_Rs),
        .IF_ID_Rt(IF_ID_Rt)
`ifdef STALL_COUNT_EN
        ,
        .Stall_Count(Stall_Count)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return rand_mem ? ((a * 32'h9E37_79B1) ^ 32'h5A5A_1234) : a;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_sc = 32'h0;
    endtask

    // Apply inputs for one cycle, advance the model on the edge, return 1 time unit after it.
    task automatic step(input bit pw, input bit iw, input bit src, input logic [31:0] bt);
        PCWrite = pw; IF_ID_Write = iw; PCSrc = src; Branch_Target = bt;
        @(posedge clk);
        if (iw) begin
            if (src) begin
                m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end else begin
                m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            end
        end
        if (pw) m_pc = src ? (bt & 32'hFFFF_FFFC) : (m_pc + 32'd4);
        if (!pw && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle with a pending redirect, held across one edge.
    task automatic pulse_reset();
        PCWrite = 1'b1; IF_ID_Write = 1'b1; PCSrc = 1'b1; Branch_Target = 32'h0000_0ABC;
        reset = 1'b1;
        #1;
        model_reset();
        chk32("async_reset_pc", PC, 32'h0);
        chk32("async_reset_instr", IF_ID_Instr, 32'h0);
        chk32("async_reset_pc4", IF_ID_PC4, 32'h0);
        chk32("async_reset_valid", {31'b0, IF_ID_Valid}, 32'h0);
`ifdef STALL_COUNT_EN
        chk32("async_reset_sc", Stall_Count, 32'h0);
`endif
        @(posedge clk);
        #2;
        reset = 1'b0;
        PCSrc = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk32("pc", PC, m_pc);
            chk32("instr", IF_ID_Instr, m_instr);
            chk32("pc4", IF_ID_PC4, m_pc4);
            chk32("valid", {31'b0, IF_ID_Valid}, {31'b0, m_valid});
            chk32("rs", {27'b0, IF_ID_Rs}, {27'b0, m_instr[25:21]});
            chk32("rt", {27'b0, IF_ID_Rt}, {27'b0, m_instr[20:16]});
`ifdef STALL_COUNT_EN
            chk32("stall_count", Stall_Count, m_sc);
`endif
        end
    end

    initial begin
        model_reset();
        #2;
        pulse_reset();
        chk_en = 1'b1;

        // Straight-line fetch with word == address
        step(1, 1, 0, 0);
        chk32("d_pc_4", PC, 32'd4);
        chk32("d_instr_0", IF_ID_Instr, 32'd0);
        chk32("d_pc4_4", IF_ID_PC4, 32'd4);
        chk32("d_valid_1", {31'b0, IF_ID_Valid}, 32'd1);
        step(1, 1, 0, 0);
        chk32("d_pc_8", PC, 32'd8);
        chk32("d_instr_4", IF_ID_Instr, 32'd4);
        // One-cycle stall at PC=8
        step(0, 0, 0, 0);
        chk32("d_stall_pc", PC, 32'd8);
        chk32("d_stall_instr", IF_ID_Instr, 32'd4);
        step(1, 1, 0, 0);
        chk32("d_resume_pc", PC, 32'd12);
        chk32("d_resume_instr", IF_ID_Instr, 32'd8);
        chk32("d_resume_pc4", IF_ID_PC4, 32'd12);
        step(1, 1, 0, 0);
        chk32("d_pc_16", PC, 32'd16);
        // Redirect with unaligned target
        step(1, 1, 1, 32'h0000_0043);
        chk32("d_br_pc", PC, 32'h40);
        chk32("d_br_instr", IF_ID_Instr, 32'h0);
        chk32("d_br_valid", {31'b0, IF_ID_Valid}, 32'd0);
        step(1, 1, 0, 0);
        chk32("d_br_cap_instr", IF_ID_Instr, 32'h40);
        chk32("d_br_cap_pc4", IF_ID_PC4, 32'h44);
        // Stall beats a simultaneous redirect, which then takes effect
        step(0, 0, 1, 32'h0000_0100);
        chk32("d_stallbr_pc", PC, 32'h44);
        chk32("d_stallbr_instr", IF_ID_Instr, 32'h40);
        chk32("d_stallbr_valid", {31'b0, IF_ID_Valid}, 32'd1);
        step(1, 1, 1, 32'h0000_0100);
        chk32("d_rebr_pc", PC, 32'h100);
        chk32("d_rebr_valid", {31'b0, IF_ID_Valid}, 32'd0);
        // PC wrap
        step(1, 1, 1, 32'hFFFF_FFFF);
        chk32("d_wrap_pre", PC, 32'hFFFF_FFFC);
        step(1, 1, 0, 0);
        chk32("d_wrap_pc", PC, 32'h0);
        chk32("d_wrap_instr", IF_ID_Instr, 32'hFFFF_FFFC);
        chk32("d_wrap_pc4", IF_ID_PC4, 32'h0);
        pulse_reset();
        step(1, 1, 0, 0);
        chk32("d_first_pc", PC, 32'd4);
        chk32("d_first_valid", {31'b0, IF_ID_Valid}, 32'd1);
        // Five stall cycles
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
`ifdef STALL_COUNT_EN
        chk32("d_sc_5", Stall_Count, 32'd5);
`endif
        pulse_reset();
`ifdef STALL_COUNT_EN
        chk32("d_sc_reset", Stall_Count, 32'd0);
`endif

        // Randomized traffic with independent stall enables and occasional resets
        rand_mem = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                pulse_reset();
            end else begin
                step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 4) == 0), $urandom);
            end
        end

        chk_en = 1'b0;
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
